// File: rtl/dg0045_pkg.sv
// Shared widths, FSM state and access record for the dg0045 RAM arbiter.
// Round-robin contention is enabled by defining DG0045_ARB_RR_EN.
package dg0045_pkg;
    localparam int ADDR_W    = 5;
    localparam int DATA_W    = 4;
    localparam int BURST_MAX = 8;
    localparam int BURST_W   = $clog2(BURST_MAX);

    typedef enum logic {IDLE, ACC} state_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } acc_req_t;
endpackage

// File: rtl/dg0045_arb_pick.sv
// Combinational winner selection: eligibility, lock masking, priority.
// DG0045_ARB_RR_EN selects round robin; otherwise port A has fixed priority.
module dg0045_arb_pick (
    input  logic req_a,
    input  logic req_b,
    input  logic locked,
    input  logic a_first,
    input  logic last_b,
    output logic pick_vld,
    output logic pick_b
);
    logic elig_a;
    logic prio_a;

    assign elig_a = req_a & ~locked;

`ifdef DG0045_ARB_RR_EN
    // a_first forces A after a burst runs out, independent of history
    assign prio_a = a_first | last_b;
`else
    logic unused_rr;
    assign unused_rr = a_first | last_b;
    assign prio_a    = 1'b1;
`endif

    assign pick_vld = elig_a | req_b;
    assign pick_b   = req_b & (~elig_a | ~prio_a);
endmodule

// File: rtl/dg0045_ram_arbiter.sv
// Two-port arbiter in front of a 32x4 combinational-read RAM; one access per
// IDLE/ACC pair, with a port-B burst lock. Option: DG0045_ARB_RR_EN.
module dg0045_ram_arbiter
    import dg0045_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_a,
    input  logic              req_b,
    input  logic              we_a,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_a,
    input  logic [DATA_W-1:0] wdata_b,
    input  logic              lock_b,
    output logic              gnt_a,
    output logic              gnt_b,
    output logic              rvalid_a,
    output logic              rvalid_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_dout
);
    state_t               state;
    logic                 acc_b;
    logic                 last_b;
    logic                 locked;
    logic                 a_first;
    logic [BURST_W-1:0]   burst_cnt;
    logic                 pick_vld;
    logic                 pick_b;
    acc_req_t             sel;

    // Dropping lock_b releases the lock in this same IDLE cycle, so A may win now
    dg0045_arb_pick u_pick (
        .req_a    (req_a),
        .req_b    (req_b),
        .locked   (locked & lock_b),
        .a_first  (a_first),
        .last_b   (last_b),
        .pick_vld (pick_vld),
        .pick_b   (pick_b)
    );

    always_comb begin
        sel = pick_b ? acc_req_t'{we_b, addr_b, wdata_b}
                     : acc_req_t'{we_a, addr_a, wdata_a};
    end

    // ram_we and gnt_* are registered on entry to ACC, so they are high for
    // exactly the ACC cycle and an async reset drops them at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            gnt_a     <= 1'b0;
            gnt_b     <= 1'b0;
            rvalid_a  <= 1'b0;
            rvalid_b  <= 1'b0;
            rdata_a   <= '0;
            rdata_b   <= '0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_din   <= '0;
            acc_b     <= 1'b0;
            last_b    <= 1'b1;
            locked    <= 1'b0;
            a_first   <= 1'b0;
            burst_cnt <= '0;
        end else begin
            gnt_a    <= 1'b0;
            gnt_b    <= 1'b0;
            rvalid_a <= 1'b0;
            rvalid_b <= 1'b0;
            ram_we   <= 1'b0;
            case (state)
                IDLE: begin
                    if (locked && !lock_b) begin
                        locked    <= 1'b0;
                        burst_cnt <= '0;
                    end
                    if (pick_vld) begin
                        state    <= ACC;
                        acc_b    <= pick_b;
                        ram_we   <= sel.we;
                        ram_addr <= sel.addr;
                        ram_din  <= sel.wdata;
                        gnt_a    <= ~pick_b;
                        gnt_b    <= pick_b;
                        last_b   <= pick_b;
                        a_first  <= 1'b0;
                        if (pick_b && lock_b) begin
                            if (burst_cnt == BURST_W'(BURST_MAX - 1)) begin
                                locked    <= 1'b0;
                                burst_cnt <= '0;
                                a_first   <= 1'b1;
                            end else begin
                                locked    <= 1'b1;
                                burst_cnt <= burst_cnt + 1'b1;
                            end
                        end
                    end
                end
                ACC: begin
                    state <= IDLE;
                    if (!ram_we) begin
                        if (acc_b) begin
                            rdata_b  <= ram_dout;
                            rvalid_b <= 1'b1;
                        end else begin
                            rdata_a  <= ram_dout;
                            rvalid_a <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dg0045_ram_arbiter.sv
// Directed self-checking bench for dg0045_ram_arbiter with a 32x4 RAM model.
// Contention expectations follow DG0045_ARB_RR_EN when it is defined.
module tb_dg0045_ram_arbiter;
    logic       clk = 1'b0;
    logic       rst;
    logic       req_a, req_b, we_a, we_b, lock_b;
    logic [4:0] addr_a, addr_b;
    logic [3:0] wdata_a, wdata_b;
    logic       gnt_a, gnt_b, rvalid_a, rvalid_b;
    logic [3:0] rdata_a, rdata_b;
    logic [4:0] ram_addr;
    logic [3:0] ram_din;
    logic       ram_we;
    logic [3:0] ram_dout;
    logic       mem_init;
    logic [3:0] mem [32];
    int         n_chk  = 0;
    int         n_pass = 0;

    always #5 clk = ~clk;

    dg0045_ram_arbiter dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
        .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
        .lock_b(lock_b),
        .gnt_a(gnt_a), .gnt_b(gnt_b), .rvalid_a(rvalid_a), .rvalid_b(rvalid_b),
        .rdata_a(rdata_a), .rdata_b(rdata_b),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
    );

    assign ram_dout = mem[ram_addr];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 32; i++) mem[i] <= 4'(i);
            mem[19] <= 4'hA;
            mem[5]  <= 4'h3;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_din;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // who: 1 = A, 2 = B, 0 = nothing within budget; cyc = cycles waited
    task automatic wait_gnt(output int who, output int cyc, input int budget);
        who = 0;
        cyc = 0;
        while (who == 0 && cyc < budget) begin
            tick();
            cyc++;
            if (gnt_a && gnt_b) who = 3;
            else if (gnt_a) who = 1;
            else if (gnt_b) who = 2;
        end
    endtask

    task automatic single(input bit b, input bit w, input logic [4:0] a,
                          input logic [3:0] d, input logic [3:0] exp, input string tag);
        if (b) begin req_b = 1; we_b = w; addr_b = a; wdata_b = d; end
        else   begin req_a = 1; we_a = w; addr_a = a; wdata_a = d; end
        tick();
        chk({tag, "_gnt"},   b ? gnt_b : gnt_a, 1);
        chk({tag, "_other"}, b ? gnt_a : gnt_b, 0);
        chk({tag, "_we"},    ram_we, w);
        chk({tag, "_addr"},  ram_addr, a);
        if (w) chk({tag, "_din"}, ram_din, d);
        chk({tag, "_rv1"},   rvalid_a | rvalid_b, 0);
        req_a = 0;
        req_b = 0;
        tick();
        chk({tag, "_gnt2"},  gnt_a | gnt_b, 0);
        chk({tag, "_we2"},   ram_we, 0);
        chk({tag, "_rv2"},   b ? rvalid_b : rvalid_a, !w);
        if (!w) chk({tag, "_rdata"}, b ? rdata_b : rdata_a, exp);
        tick();
        chk({tag, "_rv3"},   rvalid_a | rvalid_b, 0);
        if (!w) chk({tag, "_hold"}, b ? rdata_b : rdata_a, exp);
    endtask

    initial begin
        int who, cyc;
        int exp_seq [5];
        rst = 1; mem_init = 1;
        req_a = 0; req_b = 0; we_a = 0; we_b = 0; lock_b = 0;
        addr_a = 0; addr_b = 0; wdata_a = 0; wdata_b = 0;
        repeat (2) tick();
        chk("rst_gnt_a", gnt_a, 0);
        chk("rst_gnt_b", gnt_b, 0);
        chk("rst_rvalid", {rvalid_a, rvalid_b}, 0);
        chk("rst_rdata", {rdata_a, rdata_b}, 0);
        chk("rst_we", ram_we, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_din", ram_din, 0);
        mem_init = 0;
        rst = 0;
        tick();

        single(0, 0, 5'h13, 4'h0, 4'hA, "rd_a");
        single(1, 1, 5'h1F, 4'h5, 4'h0, "wr_b");
        chk("mem_1f", mem[31], 5);
        single(1, 0, 5'h1F, 4'h0, 4'h5, "rd_b");
        chk("rd_a_keep", rdata_a, 4'hA);

        // Contention straight after reset: last grant is B, so A goes first
        rst = 1; tick(); rst = 0; tick();
`ifdef DG0045_ARB_RR_EN
        exp_seq = '{1, 2, 1, 2, 2};
`else
        exp_seq = '{1, 1, 1, 1, 2};
`endif
        req_a = 1; we_a = 0; addr_a = 5'h01;
        req_b = 1; we_b = 0; addr_b = 5'h02;
        for (int k = 0; k < 5; k++) begin
            if (k == 4) req_a = 0;
            wait_gnt(who, cyc, 8);
            chk($sformatf("cont_%0d", k), who, exp_seq[k]);
            chk($sformatf("cont_gap_%0d", k), cyc, (k == 0) ? 1 : 2);
        end
        req_b = 0;
        repeat (2) tick();

        // Burst lock: 8 B grants even with A pending, then A
        req_b = 1; lock_b = 1; we_b = 0; addr_b = 5'h03;
        wait_gnt(who, cyc, 8);
        chk("lock_b_0", who, 2);
        req_a = 1; we_a = 0; addr_a = 5'h04;
        for (int k = 1; k < 8; k++) begin
            wait_gnt(who, cyc, 8);
            chk($sformatf("lock_b_%0d", k), who, 2);
        end
        wait_gnt(who, cyc, 8);
        chk("lock_then_a", who, 1);
        chk("lock_then_a_gap", cyc, 2);
        req_a = 0; req_b = 0; lock_b = 0;
        repeat (3) tick();

        // Reset in the middle of a write ACC cycle
        req_a = 1; we_a = 1; addr_a = 5'h05; wdata_a = 4'hC;
        tick();
        chk("abort_we_before", ram_we, 1);
        req_a = 0; we_a = 0;
        #2 rst = 1;
        #1;
        chk("abort_we_now", ram_we, 0);
        chk("abort_gnt_now", gnt_a, 0);
        tick();
        rst = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("abort_quiet_%0d", k), {gnt_a, gnt_b, rvalid_a, rvalid_b}, 0);
        end
        chk("abort_mem", mem[5], 3);
        single(0, 0, 5'h05, 4'h0, 4'h3, "post_rst_rd");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
